// File: rtl/io_input_pkg.sv
// Shared I/O address map and defaults for the memory-mapped port blocks.
package io_input_pkg;

    // Output-port block addresses (addr[7:2]), kept here so both blocks share one map.
    localparam logic [5:0] ADDR_OUT0 = 6'b100000;
    localparam logic [5:0] ADDR_OUT1 = 6'b100001;
    localparam logic [5:0] ADDR_OUT2 = 6'b100010;
    localparam logic [5:0] ADDR_OUT3 = 6'b100011;

    // Input-port block addresses (addr[7:2]).
    localparam logic [5:0] ADDR_IN_PORT0  = 6'b110000;
    localparam logic [5:0] ADDR_IN_PORT1  = 6'b110001;
    localparam logic [5:0] ADDR_IN_PORT2  = 6'b110010;
    localparam logic [5:0] ADDR_IN_PORT3  = 6'b110011;
    localparam logic [5:0] ADDR_IN_FLAGS  = 6'b110100;
    localparam logic [5:0] ADDR_IN_STABLE = 6'b110101;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/io_input_if.sv
// CPU-side load bus of the input-port block.
interface io_input_if;
    logic [31:0] addr;
    logic        read_io_enable;
    logic [31:0] dataout;
    logic        irq;

    modport master (output addr, output read_io_enable, input dataout, input irq);
    modport slave  (input addr, input read_io_enable, output dataout, output irq);
endinterface

// File: rtl/io_input_debounce.sv
// One button bit: two-flop synchronizer, debounce counter and accepted level.
// rise is high in the cycle whose edge accepts a 0->1 change of stable.
module io_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        meta;
    logic        sync;
    logic [15:0] cnt;
    logic        accept;

    assign accept = (sync != stable) && (cnt == LAST);
    assign rise   = accept && sync;

    // Synchronize, then count consecutive cycles the level differs from stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/io_input.sv
// Memory-mapped input-port block: synchronized data ports, debounced buttons,
// rising-edge flags with clear-on-read, and an irq while any flag is pending.
module io_input
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int NBTN            = 4
) (
    input  logic        io_clk,
    input  logic        clr,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    input  logic [31:0] in_port3,
    io_input_if.slave   bus
);
    logic [31:0]     p0_meta, p0_sync;
    logic [31:0]     p1_meta, p1_sync;
    logic [31:0]     p2_meta, p2_sync;
    logic [31:NBTN]  p3_meta, p3_sync;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] flag;
    logic [NBTN-1:0] flag_clr;
    logic [5:0]      sel;
    logic [31:0]     dout;
    logic            unused_addr;

    assign sel         = bus.addr[7:2];
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

    // Button bits get their own synchronizer inside each debounce slice.
    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        io_input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (io_clk),
            .rst    (clr),
            .raw    (in_port3[b]),
            .stable (stable[b]),
            .rise   (rise[b])
        );
    end

    // Two-flop synchronizers for the plain data bits.
    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            p0_meta <= '0;
            p0_sync <= '0;
            p1_meta <= '0;
            p1_sync <= '0;
            p2_meta <= '0;
            p2_sync <= '0;
            p3_meta <= '0;
            p3_sync <= '0;
        end else begin
            p0_meta <= in_port0;
            p0_sync <= p0_meta;
            p1_meta <= in_port1;
            p1_sync <= p1_meta;
            p2_meta <= in_port2;
            p2_sync <= p2_meta;
            p3_meta <= in_port3[31:NBTN];
            p3_sync <= p3_meta;
        end
    end

    // Only the flags visible in this read are cleared; a new rise still wins.
    assign flag_clr = (bus.read_io_enable && (sel == ADDR_IN_FLAGS)) ? flag : '0;

    // Edge flags: set on accepted rising edges, cleared by a flag read.
    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            flag <= '0;
        end else begin
            flag <= (flag & ~flag_clr) | rise;
        end
    end

    // Read mux, independent of read_io_enable for single-cycle loads.
    always_comb begin
        dout = '0;
        case (sel)
            ADDR_IN_PORT0:  dout = p0_sync;
            ADDR_IN_PORT1:  dout = p1_sync;
            ADDR_IN_PORT2:  dout = p2_sync;
            ADDR_IN_PORT3:  dout = {p3_sync, stable};
            ADDR_IN_FLAGS:  dout = {{(32-NBTN){1'b0}}, flag};
            ADDR_IN_STABLE: dout = {{(32-NBTN){1'b0}}, stable};
            default:        dout = '0;
        endcase
    end

    assign bus.dataout = dout;
    assign bus.irq     = |flag;
endmodule
